// File: rtl/mycpu_pkg.sv
// Shared types and defaults for the mycpu bus arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : which requester currently holds the bus
//   ARB_*_DEF   : default wait-state and starvation limits
package mycpu_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_ACK
  } arb_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DMA
  } owner_t;

  localparam int ARB_WAIT_STATES_DEF = 1;
  localparam int ARB_STARVE_MAX_DEF  = 4;

endpackage

// File: rtl/bus_arb.sv
// Two-requester arbiter (CPU datapath and DMA/loader) for the single mycpu
// memory/IO bus. One access at a time; each access holds the bus for
// WAIT_STATES+1 cycles, then a one-cycle ack state returns read data.
//
// State table:
//   ARB_IDLE   | sample requests, grant and latch the access onto bus_*
//   ARB_ACCESS | bus_en high; count down wait states, capture read data
//   ARB_ACK    | owner's ack flag high for this cycle; requests ignored
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cpu_req/we/iom/addr/wdata_in    CPU request (level, held until stall drops)
//   cpu_rdata_out, cpu_stall_out    CPU read data (registered), stall (comb)
//   dma_req/we/iom/addr/wdata_in    DMA request fields
//   dma_rdata_out, dma_ack_out      DMA read data, one-cycle completion pulse
//   bus_en/we/iom/addr/wdata_out    latched bus access
//   bus_rdata_in                    bus read data, valid in last access cycle
module bus_arb
  import mycpu_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = ARB_WAIT_STATES_DEF,
  parameter int STARVE_MAX  = ARB_STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_in,
  input  logic              cpu_we_in,
  input  logic              cpu_iom_in,
  input  logic [ADDR_W-1:0] cpu_addr_in,
  input  logic [DATA_W-1:0] cpu_wdata_in,
  output logic [DATA_W-1:0] cpu_rdata_out,
  output logic              cpu_stall_out,
  input  logic              dma_req_in,
  input  logic              dma_we_in,
  input  logic              dma_iom_in,
  input  logic [ADDR_W-1:0] dma_addr_in,
  input  logic [DATA_W-1:0] dma_wdata_in,
  output logic [DATA_W-1:0] dma_rdata_out,
  output logic              dma_ack_out,
  output logic              bus_en_out,
  output logic              bus_we_out,
  output logic              bus_iom_out,
  output logic [ADDR_W-1:0] bus_addr_out,
  output logic [DATA_W-1:0] bus_wdata_out,
  input  logic [DATA_W-1:0] bus_rdata_in
);

  localparam int WAIT_W   = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [WAIT_W-1:0]   WAIT_INIT  = WAIT_W'(WAIT_STATES);
  localparam logic [STARVE_W-1:0] STARVE_SAT = STARVE_W'(STARVE_MAX);

  arb_state_t          state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                bus_en_q, bus_en_d;
  logic                bus_we_q, bus_we_d;
  logic                bus_iom_q, bus_iom_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                dma_ack_q, dma_ack_d;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    bus_en_d     = 1'b0;
    bus_we_d     = bus_we_q;
    bus_iom_d    = bus_iom_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    cpu_ack_d    = 1'b0;
    dma_ack_d    = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (!dma_req_in) starve_cnt_d = '0;
        if (dma_req_in && (!cpu_req_in || starve_cnt_q == STARVE_SAT)) begin
          owner_d      = OWN_DMA;
          bus_we_d     = dma_we_in;
          bus_iom_d    = dma_iom_in;
          bus_addr_d   = dma_addr_in;
          bus_wdata_d  = dma_wdata_in;
          starve_cnt_d = '0;
          wait_cnt_d   = WAIT_INIT;
          bus_en_d     = 1'b1;
          state_d      = ARB_ACCESS;
        end else if (cpu_req_in) begin
          owner_d     = OWN_CPU;
          bus_we_d    = cpu_we_in;
          bus_iom_d   = cpu_iom_in;
          bus_addr_d  = cpu_addr_in;
          bus_wdata_d = cpu_wdata_in;
          // A CPU win over a waiting DMA implies the counter is below the
          // limit, so the increment cannot overshoot.
          if (dma_req_in) starve_cnt_d = starve_cnt_q + 1'b1;
          wait_cnt_d  = WAIT_INIT;
          bus_en_d    = 1'b1;
          state_d     = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - 1'b1;
          bus_en_d   = 1'b1;
        end else begin
          if (!bus_we_q) begin
            if (owner_q == OWN_DMA) dma_rdata_d = bus_rdata_in;
            else                    cpu_rdata_d = bus_rdata_in;
          end
          if (owner_q == OWN_DMA) dma_ack_d = 1'b1;
          else                    cpu_ack_d = 1'b1;
          state_d = ARB_ACK;
        end
      end
      ARB_ACK: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_CPU;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
      bus_en_q     <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_iom_q    <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      bus_en_q     <= bus_en_d;
      bus_we_q     <= bus_we_d;
      bus_iom_q    <= bus_iom_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_ack_q    <= dma_ack_d;
    end
  end

  // Stall releases in the ack cycle so the cu advances exactly once.
  assign cpu_stall_out = cpu_req_in & ~cpu_ack_q;
  assign cpu_rdata_out = cpu_rdata_q;
  assign dma_rdata_out = dma_rdata_q;
  assign dma_ack_out   = dma_ack_q;
  assign bus_en_out    = bus_en_q;
  assign bus_we_out    = bus_we_q;
  assign bus_iom_out   = bus_iom_q;
  assign bus_addr_out  = bus_addr_q;
  assign bus_wdata_out = bus_wdata_q;

endmodule

// File: tb/tb_bus_arb.sv
// Randomized scoreboard bench for bus_arb. Two instances share the clock,
// reset and bus read data: instance 0 with WAIT_STATES=1, instance 1 with
// WAIT_STATES=0, both STARVE_MAX=4. Each instance has its own requesters.
module tb_bus_arb;

  localparam int SM   = 4;
  localparam int NCYC = 1500;
  localparam int TBL  = 4096;

  logic        clk, rst_n;
  logic        cpu_req[2], cpu_we[2], cpu_iom[2];
  logic        dma_req[2], dma_we[2], dma_iom[2];
  logic [15:0] cpu_addr[2], cpu_wdata[2], dma_addr[2], dma_wdata[2];
  logic [15:0] cpu_rdata[2], dma_rdata[2], bus_addr[2], bus_wdata[2];
  logic        cpu_stall[2], dma_ack[2], bus_en[2], bus_we[2], bus_iom[2];
  logic [15:0] bus_rdata;

  bus_arb #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(1), .STARVE_MAX(SM)) u_ws1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_in(cpu_req[0]), .cpu_we_in(cpu_we[0]), .cpu_iom_in(cpu_iom[0]),
    .cpu_addr_in(cpu_addr[0]), .cpu_wdata_in(cpu_wdata[0]),
    .cpu_rdata_out(cpu_rdata[0]), .cpu_stall_out(cpu_stall[0]),
    .dma_req_in(dma_req[0]), .dma_we_in(dma_we[0]), .dma_iom_in(dma_iom[0]),
    .dma_addr_in(dma_addr[0]), .dma_wdata_in(dma_wdata[0]),
    .dma_rdata_out(dma_rdata[0]), .dma_ack_out(dma_ack[0]),
    .bus_en_out(bus_en[0]), .bus_we_out(bus_we[0]), .bus_iom_out(bus_iom[0]),
    .bus_addr_out(bus_addr[0]), .bus_wdata_out(bus_wdata[0]),
    .bus_rdata_in(bus_rdata)
  );

  bus_arb #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(0), .STARVE_MAX(SM)) u_ws0 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_in(cpu_req[1]), .cpu_we_in(cpu_we[1]), .cpu_iom_in(cpu_iom[1]),
    .cpu_addr_in(cpu_addr[1]), .cpu_wdata_in(cpu_wdata[1]),
    .cpu_rdata_out(cpu_rdata[1]), .cpu_stall_out(cpu_stall[1]),
    .dma_req_in(dma_req[1]), .dma_we_in(dma_we[1]), .dma_iom_in(dma_iom[1]),
    .dma_addr_in(dma_addr[1]), .dma_wdata_in(dma_wdata[1]),
    .dma_rdata_out(dma_rdata[1]), .dma_ack_out(dma_ack[1]),
    .bus_en_out(bus_en[1]), .bus_we_out(bus_we[1]), .bus_iom_out(bus_iom[1]),
    .bus_addr_out(bus_addr[1]), .bus_wdata_out(bus_wdata[1]),
    .bus_rdata_in(bus_rdata)
  );

  typedef struct {
    int          inst;
    bit          own_dma;
    bit          we;
    bit          iom;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          start;
    int          ack;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] rd_tbl[TBL];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          free_t[2], starve[2], cpu_ack_t[2], dma_ack_t[2];
  bit          cpu_pend[2], dma_pend[2], cpu_gr[2], dma_gr[2];
  logic [15:0] last_rd[2][2];
  int          rst_cycle = -1;
  bit          rst_arm = 0;
  bit          run = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d actual=0x%0h expected=0x%0h",
               name, i, cyc, act, exp);
    end
  endtask

  function automatic int find_front(input int i);
    foreach (sb_q[k]) if (sb_q[k].inst == i) return k;
    return -1;
  endfunction

  task automatic drive_req(input int i, input int t, input int p_cpu, input int p_dma);
    if (cpu_pend[i] && cpu_gr[i] && t > cpu_ack_t[i]) cpu_pend[i] = 0;
    if (!cpu_pend[i] && $urandom_range(99) < p_cpu) begin
      cpu_pend[i] = 1; cpu_gr[i] = 0; cpu_req[i] = 1'b1;
      cpu_we[i] = 1'($urandom); cpu_iom[i] = 1'($urandom);
      cpu_addr[i] = 16'($urandom); cpu_wdata[i] = 16'($urandom);
    end else if (!cpu_pend[i] || cpu_gr[i]) begin
      // Idle or already granted: field values must not matter to the arbiter.
      if (!cpu_pend[i]) cpu_req[i] = 1'b0;
      cpu_we[i] = 1'($urandom); cpu_iom[i] = 1'($urandom);
      cpu_addr[i] = 16'($urandom); cpu_wdata[i] = 16'($urandom);
    end
    if (dma_pend[i] && dma_gr[i] && t > dma_ack_t[i]) dma_pend[i] = 0;
    if (!dma_pend[i] && $urandom_range(99) < p_dma) begin
      dma_pend[i] = 1; dma_gr[i] = 0; dma_req[i] = 1'b1;
      dma_we[i] = 1'($urandom); dma_iom[i] = 1'($urandom);
      dma_addr[i] = 16'($urandom); dma_wdata[i] = 16'($urandom);
    end else if (!dma_pend[i] || dma_gr[i]) begin
      if (!dma_pend[i]) dma_req[i] = 1'b0;
      dma_we[i] = 1'($urandom); dma_iom[i] = 1'($urandom);
      dma_addr[i] = 16'($urandom); dma_wdata[i] = 16'($urandom);
    end
  endtask

  // Reference: the bus is free from free_t on; a grant at cycle t occupies
  // t+1..t+ws+1 and acks at t+ws+2, next arbitration at t+ws+3.
  task automatic model(input int i, input int t);
    exp_t e;
    bit   gdma;
    int   ws;
    ws = ws_of(i);
    if (t < free_t[i]) return;
    if (!dma_req[i]) starve[i] = 0;
    if (!cpu_req[i] && !dma_req[i]) return;
    gdma = dma_req[i] && (!cpu_req[i] || starve[i] == SM);
    if (gdma) starve[i] = 0;
    else if (dma_req[i]) starve[i] = (starve[i] + 1 > SM) ? SM : starve[i] + 1;
    e.inst    = i;
    e.own_dma = gdma;
    e.we      = gdma ? dma_we[i]    : cpu_we[i];
    e.iom     = gdma ? dma_iom[i]   : cpu_iom[i];
    e.addr    = gdma ? dma_addr[i]  : cpu_addr[i];
    e.wdata   = gdma ? dma_wdata[i] : cpu_wdata[i];
    e.start   = t + 1;
    e.ack     = t + ws + 2;
    if (!e.we) last_rd[i][gdma] = rd_tbl[t + ws + 1];
    e.rdata   = last_rd[i][gdma];
    sb_q.push_back(e);
    free_t[i] = t + ws + 3;
    if (gdma) begin
      dma_gr[i] = 1; dma_ack_t[i] = e.ack;
    end else begin
      cpu_gr[i] = 1; cpu_ack_t[i] = e.ack;
      if (i == 0 && rst_arm) begin
        rst_cycle = t + 1;
        rst_arm   = 0;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_bus_en"}, i, bus_en[i], 0);
      chk({tag, "_bus_we"}, i, bus_we[i], 0);
      chk({tag, "_bus_iom"}, i, bus_iom[i], 0);
      chk({tag, "_bus_addr"}, i, bus_addr[i], 0);
      chk({tag, "_bus_wdata"}, i, bus_wdata[i], 0);
      chk({tag, "_cpu_rdata"}, i, cpu_rdata[i], 0);
      chk({tag, "_dma_rdata"}, i, dma_rdata[i], 0);
      chk({tag, "_dma_ack"}, i, dma_ack[i], 0);
      chk({tag, "_stall"}, i, cpu_stall[i], cpu_req[i]);
    end
  endtask

  task automatic mid_access_reset(input int t);
    chk("pre_rst_bus_en", 0, bus_en[0], 1);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    sb_q.delete();
    for (int i = 0; i < 2; i++) begin
      free_t[i] = t; starve[i] = 0; cpu_gr[i] = 0; dma_gr[i] = 0;
      last_rd[i][0] = '0; last_rd[i][1] = '0;
    end
    #2 rst_n = 1'b1;
  endtask

  // Scoreboard monitor: compares every cycle, retires an entry at its ack.
  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < 2; i++) begin
        int   idx;
        exp_t e;
        bit   in_acc, ack_now;
        idx = find_front(i);
        in_acc = 0; ack_now = 0; e.own_dma = 0;
        if (idx >= 0) begin
          e       = sb_q[idx];
          in_acc  = (cyc >= e.start) && (cyc < e.ack);
          ack_now = (cyc == e.ack);
        end
        chk("bus_en", i, bus_en[i], in_acc);
        if (in_acc) begin
          chk("bus_addr", i, bus_addr[i], e.addr);
          chk("bus_wdata", i, bus_wdata[i], e.wdata);
          chk("bus_we", i, bus_we[i], e.we);
          chk("bus_iom", i, bus_iom[i], e.iom);
        end
        chk("dma_ack", i, dma_ack[i], ack_now && e.own_dma);
        chk("cpu_stall", i, cpu_stall[i], cpu_req[i] && !(ack_now && !e.own_dma));
        if (ack_now) begin
          if (e.own_dma) chk("dma_rdata", i, dma_rdata[i], e.rdata);
          else           chk("cpu_rdata", i, cpu_rdata[i], e.rdata);
          sb_q.delete(idx);
        end
      end
    end
  end

  initial begin
    int t, p_cpu, p_dma;
    for (int k = 0; k < TBL; k++) rd_tbl[k] = 16'($urandom);
    rst_n = 1'b0;
    bus_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      cpu_req[i] = (i == 0); cpu_we[i] = 0; cpu_iom[i] = 0;
      cpu_addr[i] = '0; cpu_wdata[i] = '0;
      dma_req[i] = 0; dma_we[i] = 0; dma_iom[i] = 0;
      dma_addr[i] = '0; dma_wdata[i] = '0;
      cpu_pend[i] = 0; dma_pend[i] = 0; cpu_gr[i] = 0; dma_gr[i] = 0;
      starve[i] = 0; cpu_ack_t[i] = 0; dma_ack_t[i] = 0;
      last_rd[i][0] = '0; last_rd[i][1] = '0;
    end
    #3 chk_reset_outputs("rst_init");
    cpu_req[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run = 1;
    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk);
      #1;
      t = cyc;
      if (n == 0) begin
        free_t[0] = t; free_t[1] = t;
      end
      bus_rdata = rd_tbl[t];
      if (n < 1000)      begin p_cpu = 35;  p_dma = 35;  end
      else if (n < 1200) begin p_cpu = 100; p_dma = 100; end
      else               begin p_cpu = 100; p_dma = 0;   end
      if (n == 1300) rst_arm = 1;
      for (int i = 0; i < 2; i++) drive_req(i, t, p_cpu, p_dma);
      if (t == rst_cycle) mid_access_reset(t);
      for (int i = 0; i < 2; i++) model(i, t);
    end
    @(posedge clk);
    run = 0;
    if (rst_cycle < 0) chk("rst_mid_reached", 0, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
